// File: rtl/cap64_bounds_encoder_if.sv
// Compressed capability layout and the valid/ready bundle of cap64_bounds_encoder.
package cap64_pkg;

  typedef struct packed {
    logic [15:0] perms;
    logic        flags;
    logic [1:0]  resv;
    logic [17:0] otype;
    logic        ie;
    logic [8:0]  t;
    logic [2:0]  te;
    logic [10:0] b;
    logic [2:0]  be;
    logic [63:0] a;
  } capability64_t;

endpackage

interface cap64_bounds_encoder_if;
  import cap64_pkg::*;

  logic          i_valid;
  logic          i_ready;
  logic [63:0]   i_base;
  logic [63:0]   i_len;
  logic [15:0]   i_perms;
  logic [17:0]   i_otype;
  logic          i_req_exact;
  logic          o_valid;
  logic          o_ready;
  capability64_t o_cap;
  logic          o_exact;
  logic          o_fault;

  modport master (
    output i_valid, i_base, i_len, i_perms, i_otype, i_req_exact, o_ready,
    input  i_ready, o_valid, o_cap, o_exact, o_fault
  );

  modport slave (
    input  i_valid, i_base, i_len, i_perms, i_otype, i_req_exact, o_ready,
    output i_ready, o_valid, o_cap, o_exact, o_fault
  );

endinterface

// File: rtl/cap64_bounds_encoder.sv
// Multi-cycle base/length -> compressed capability encoder (IDLE/CALC/ENC/REENC/DONE).
// Optional exact-bounds fault reporting is enabled with `define CAP_ENC_EXACT_EN.
module cap64_bounds_encoder #(
  parameter int unsigned EXP_MAX   = 50,
  parameter int unsigned IE_THRESH = 11
) (
  input logic                   clk,
  input logic                   rst,
  cap64_bounds_encoder_if.slave bus
);
  import cap64_pkg::*;

  localparam logic [6:0]  MANT_LSB  = 7'd3;
  localparam logic [64:0] OVF_LIMIT = 65'd1 << (IE_THRESH - 3);
  localparam logic [63:0] IE_LIMIT  = 64'd1 << IE_THRESH;
  localparam logic [6:0]  E_BIAS    = 7'(IE_THRESH - 1);
  localparam logic [5:0]  E_MAX     = 6'(EXP_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ENC   = 3'd2,
    S_REENC = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [5:0] msb_index(input logic [63:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      idx = v[i] ? 6'(i) : idx;
    end
    return idx;
  endfunction

  state_t        r_state;
  logic          r_i_ready;
  logic          r_o_valid;
  capability64_t r_o_cap;
  logic          r_o_exact;
  logic          r_o_fault;
  logic [63:0]   r_base;
  logic [63:0]   r_len;
  logic [64:0]   r_top;
  logic [15:0]   r_perms;
  logic [17:0]   r_otype;
  logic [5:0]    r_e;
  logic          r_ie;
  logic          r_sat;
`ifdef CAP_ENC_EXACT_EN
  logic          r_req_exact;
`endif

  logic [5:0]    w_m;
  logic [6:0]    w_e_raw;
  logic [6:0]    w_sh;
  logic [64:0]   w_mask;
  logic [64:0]   w_top_sh;
  logic [63:0]   w_base_sh;
  logic [64:0]   w_top_up;
  logic [64:0]   w_rlen;
  logic          w_top_lo_nz;
  logic          w_base_lo_nz;
  logic          w_enc_exact;
  logic          w_enc_ovf;
  logic          w_exact;
  logic          w_fault;
  capability64_t w_cap;

  // w_e_raw wraps for short lengths, but it is only consulted once len >= 2**IE_THRESH
  assign w_m     = msb_index(r_len);
  assign w_e_raw = {1'b0, w_m} - E_BIAS;

  assign bus.i_ready = r_i_ready;
  assign bus.o_valid = r_o_valid;
  assign bus.o_cap   = r_o_cap;
  assign bus.o_exact = r_o_exact;
  assign bus.o_fault = r_o_fault;

  // Granule rounding at the current exponent: base down, top up, rounded length in granules.
  always_comb begin
    w_sh         = {1'b0, r_e} + MANT_LSB;
    w_mask       = (65'd1 << w_sh) - 65'd1;
    w_top_sh     = r_top >> w_sh;
    w_base_sh    = r_base >> w_sh;
    w_top_lo_nz  = |(r_top & w_mask);
    w_base_lo_nz = |(r_base & w_mask[63:0]);
    w_top_up     = w_top_sh + {64'd0, w_top_lo_nz};
    w_rlen       = w_top_up - {1'b0, w_base_sh};
  end

  // Assemble the candidate capability and its exactness/fault flags.
  always_comb begin
    w_cap       = '0;
    w_cap.a     = r_base;
    w_cap.otype = r_otype;
    w_cap.perms = r_perms;
    w_enc_exact = 1'b1;
    w_enc_ovf   = 1'b0;
    w_fault     = 1'b0;
    if (r_ie) begin
      w_cap.ie = 1'b1;
      w_cap.te = r_e[5:3];
      w_cap.be = r_e[2:0];
      w_cap.b  = w_base_sh[10:0];
      if (r_sat) begin
        w_cap.t     = 9'h1FF;
        w_enc_exact = 1'b0;
        w_enc_ovf   = 1'b0;
      end else begin
        w_cap.t     = w_top_up[8:0];
        w_enc_exact = !w_base_lo_nz && !w_top_lo_nz;
        w_enc_ovf   = (w_rlen >= OVF_LIMIT) && (r_e < E_MAX);
      end
    end else begin
      w_cap.ie    = 1'b0;
      w_cap.b     = r_base[13:3];
      w_cap.be    = r_base[2:0];
      w_cap.t     = r_top[11:3];
      w_cap.te    = r_top[2:0];
      w_enc_exact = 1'b1;
      w_enc_ovf   = 1'b0;
    end
    // A re-encode only happens after rounding already changed the bounds
    w_exact = w_enc_exact && (r_state != S_REENC);
`ifdef CAP_ENC_EXACT_EN
    w_fault = r_req_exact & ~w_exact;
    if (w_fault) begin
      w_cap.perms = 16'd0;
    end else begin
      w_cap.perms = r_perms;
    end
`else
    w_fault = 1'b0;
`endif
  end

  // Request FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_i_ready <= 1'b1;
      r_o_valid <= 1'b0;
      r_o_cap   <= '0;
      r_o_exact <= 1'b0;
      r_o_fault <= 1'b0;
      r_base    <= 64'd0;
      r_len     <= 64'd0;
      r_top     <= 65'd0;
      r_perms   <= 16'd0;
      r_otype   <= 18'd0;
      r_e       <= 6'd0;
      r_ie      <= 1'b0;
      r_sat     <= 1'b0;
`ifdef CAP_ENC_EXACT_EN
      r_req_exact <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_base    <= bus.i_base;
            r_len     <= bus.i_len;
            r_perms   <= bus.i_perms;
            r_otype   <= bus.i_otype;
`ifdef CAP_ENC_EXACT_EN
            r_req_exact <= bus.i_req_exact;
`endif
            r_i_ready <= 1'b0;
            r_state   <= S_CALC;
          end else begin
            r_i_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_CALC: begin
          r_top <= {1'b0, r_base} + {1'b0, r_len};
          if (r_len < IE_LIMIT) begin
            r_ie  <= 1'b0;
            r_e   <= 6'd0;
            r_sat <= 1'b0;
          end else if (w_e_raw > {1'b0, E_MAX}) begin
            r_ie  <= 1'b1;
            r_e   <= E_MAX;
            r_sat <= 1'b1;
          end else begin
            r_ie  <= 1'b1;
            r_e   <= w_e_raw[5:0];
            r_sat <= 1'b0;
          end
          r_state <= S_ENC;
        end
        S_ENC: begin
          if (w_enc_ovf) begin
            r_e     <= r_e + 6'd1;
            r_state <= S_REENC;
          end else begin
            r_o_cap   <= w_cap;
            r_o_exact <= w_exact;
            r_o_fault <= w_fault;
            r_o_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_REENC: begin
          r_o_cap   <= w_cap;
          r_o_exact <= w_exact;
          r_o_fault <= w_fault;
          r_o_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (bus.o_ready) begin
            r_o_valid <= 1'b0;
            r_i_ready <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_o_valid <= 1'b1;
            r_i_ready <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_i_ready <= 1'b1;
          r_o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cap64_bounds_encoder.sv
// Directed self-checking bench for cap64_bounds_encoder with hand-computed vectors.
module tb_cap64_bounds_encoder;
  import cap64_pkg::*;

`ifdef CAP_ENC_EXACT_EN
  localparam logic FLT_EN = 1'b1;
`else
  localparam logic FLT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  cap64_bounds_encoder_if bus ();

  cap64_bounds_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic capability64_t mk(input logic [15:0] p, input logic [17:0] ot,
                                       input logic ie, input logic [8:0] t, input logic [2:0] te,
                                       input logic [10:0] b, input logic [2:0] be,
                                       input logic [63:0] a);
    capability64_t c;
    c       = '0;
    c.perms = p;
    c.otype = ot;
    c.ie    = ie;
    c.t     = t;
    c.te    = te;
    c.b     = b;
    c.be    = be;
    c.a     = a;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [63:0] base, input logic [63:0] len,
                       input logic [15:0] perms, input logic [17:0] otype, input logic rx,
                       input capability64_t exp_cap, input logic exp_exact,
                       input logic exp_fault, input int exp_lat);
    int lat;
    chk({tag, ".i_ready"}, {127'd0, bus.i_ready}, 128'd1);
    bus.i_valid     = 1'b1;
    bus.i_base      = base;
    bus.i_len       = len;
    bus.i_perms     = perms;
    bus.i_otype     = otype;
    bus.i_req_exact = rx;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    lat = 1;
    while (bus.o_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, ".cap"}, bus.o_cap, exp_cap);
    chk({tag, ".exact"}, {127'd0, bus.o_exact}, {127'd0, exp_exact});
    chk({tag, ".fault"}, {127'd0, bus.o_fault}, {127'd0, exp_fault});
  endtask

  task automatic retire(input string tag);
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".o_valid_drop"}, {127'd0, bus.o_valid}, 128'd0);
    chk({tag, ".i_ready_back"}, {127'd0, bus.i_ready}, 128'd1);
  endtask

  initial begin
    capability64_t held;
    clk             = 1'b0;
    rst             = 1'b1;
    n_cmp           = 0;
    n_fail          = 0;
    bus.i_valid     = 1'b0;
    bus.i_base      = 64'd0;
    bus.i_len       = 64'd0;
    bus.i_perms     = 16'd0;
    bus.i_otype     = 18'd0;
    bus.i_req_exact = 1'b0;
    bus.o_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.i_ready", {127'd0, bus.i_ready}, 128'd1);
    chk("rst.o_valid", {127'd0, bus.o_valid}, 128'd0);
    chk("rst.o_cap", bus.o_cap, 128'd0);
    chk("rst.o_exact", {127'd0, bus.o_exact}, 128'd0);
    chk("rst.o_fault", {127'd0, bus.o_fault}, 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Exponent-zero form
    issue("v1_ie0", 64'h1000, 64'h100, 16'hABCD, 18'h12345, 1'b0,
          mk(16'hABCD, 18'h12345, 1'b0, 9'h020, 3'd0, 11'h200, 3'd0, 64'h1000), 1'b1, 1'b0, 3);
    retire("v1");
    issue("v2_e6", 64'h0, 64'h10000, 16'h0F0F, 18'h00001, 1'b0,
          mk(16'h0F0F, 18'h00001, 1'b1, 9'h080, 3'd0, 11'h000, 3'd6, 64'h0), 1'b1, 1'b0, 3);
    retire("v2");
    issue("v3_inexact", 64'h1001, 64'h10000, 16'h1234, 18'h00002, 1'b1,
          mk(FLT_EN ? 16'h0000 : 16'h1234, 18'h00002, 1'b1, 9'h089, 3'd0, 11'h008, 3'd6, 64'h1001),
          1'b0, FLT_EN, 3);
    retire("v3");
    issue("v3b_norx", 64'h1001, 64'h10000, 16'h1234, 18'h00002, 1'b0,
          mk(16'h1234, 18'h00002, 1'b1, 9'h089, 3'd0, 11'h008, 3'd6, 64'h1001), 1'b0, 1'b0, 3);
    retire("v3b");
    // Rounding up to 2**(E+11) forces a second pass at E+1
    issue("v4_reenc", 64'h1, 64'hFFF, 16'h5555, 18'h3FFFF, 1'b0,
          mk(16'h5555, 18'h3FFFF, 1'b1, 9'h080, 3'd0, 11'h000, 3'd2, 64'h1), 1'b0, 1'b0, 4);
    retire("v4");
    issue("v5_len7ff", 64'h0, 64'h7FF, 16'h0001, 18'h0, 1'b0,
          mk(16'h0001, 18'h0, 1'b0, 9'h0FF, 3'd7, 11'h000, 3'd0, 64'h0), 1'b1, 1'b0, 3);
    retire("v5");
    issue("v6_len800", 64'h0, 64'h800, 16'h0002, 18'h0, 1'b0,
          mk(16'h0002, 18'h0, 1'b1, 9'h080, 3'd0, 11'h000, 3'd1, 64'h0), 1'b1, 1'b0, 3);
    retire("v6");
    issue("v7_emax", 64'h0, 64'h1000_0000_0000_0000, 16'h0003, 18'h0, 1'b0,
          mk(16'h0003, 18'h0, 1'b1, 9'h080, 3'd6, 11'h000, 3'd2, 64'h0), 1'b1, 1'b0, 3);
    retire("v7");
    issue("v8_sat", 64'hFFE0_0000_0000_0000, 64'h4000_0000_0000_0000, 16'h0004, 18'h0, 1'b0,
          mk(16'h0004, 18'h0, 1'b1, 9'h1FF, 3'd6, 11'h7FF, 3'd2, 64'hFFE0_0000_0000_0000),
          1'b0, 1'b0, 3);
    retire("v8");

    // Consumer stall: result held, new requests ignored
    bus.o_ready = 1'b0;
    held = mk(16'h0002, 18'h0, 1'b1, 9'h080, 3'd0, 11'h000, 3'd1, 64'h0);
    issue("stall", 64'h0, 64'h800, 16'h0002, 18'h0, 1'b0, held, 1'b1, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = 1'b1;
      bus.i_base  = 64'(i + 7);
      bus.i_len   = 64'h40;
      @(posedge clk);
      #1;
      chk("stall.o_valid", {127'd0, bus.o_valid}, 128'd1);
      chk("stall.i_ready", {127'd0, bus.i_ready}, 128'd0);
      chk("stall.o_cap", bus.o_cap, held);
    end
    bus.i_valid = 1'b0;
    retire("stall");
    issue("v9_len0", 64'h1234, 64'h0, 16'h0005, 18'h0, 1'b0,
          mk(16'h0005, 18'h0, 1'b0, 9'h046, 3'd4, 11'h246, 3'd4, 64'h1234), 1'b1, 1'b0, 3);
    retire("v9");

    // Reset while the request sits in ENC
    bus.i_valid = 1'b1;
    bus.i_base  = 64'h1000;
    bus.i_len   = 64'h100;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.o_valid", {127'd0, bus.o_valid}, 128'd0);
    chk("abort.i_ready", {127'd0, bus.i_ready}, 128'd1);
    chk("abort.o_cap", bus.o_cap, 128'd0);
    chk("abort.o_exact", {127'd0, bus.o_exact}, 128'd0);
    rst = 1'b0;
    issue("post_abort", 64'h0, 64'h10000, 16'h0F0F, 18'h00001, 1'b0,
          mk(16'h0F0F, 18'h00001, 1'b1, 9'h080, 3'd0, 11'h000, 3'd6, 64'h0), 1'b1, 1'b0, 3);
    retire("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
